// File: rtl/bulls_cows_param_if.sv
// Front-end / display-side bundle of the Bulls & Cows controller.
// The front-end side (switches, enter button, abort, display sink) is the
// master; the game controller is the slave.
interface bulls_cows_param_if #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4
);
  logic [N_DIGITS*DIGIT_W-1:0] SW;
  logic                        ssl;
  logic                        game_over;
  logic [5:0]                  d1, d2, d3, d4, d5, d6, d7, d8;
  logic                        p1_win;
  logic                        p2_win;
  logic                        draw;

  modport master (
    output SW, ssl, game_over,
    input  d1, d2, d3, d4, d5, d6, d7, d8, p1_win, p2_win, draw
  );

  modport slave (
    input  SW, ssl, game_over,
    output d1, d2, d3, d4, d5, d6, d7, d8, p1_win, p2_win, draw
  );
endinterface

// File: rtl/bulls_cows_param.sv
// Two-player Bulls & Cows game controller with configurable code length,
// digit width, digit range and per-player attempt limit (draw when both
// players run out). Produces eight registered 6-bit display codes.
module bulls_cows_param #(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9,
  parameter int MAX_TRIES = 8
) (
  input  logic              clock,
  input  logic              reset,
  bulls_cows_param_if.slave bus
);
  localparam int SW_W = N_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MAX_D     = DIGIT_W'(MAX_DIGIT);
  localparam logic [3:0]         TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [3:0]         DIGITS_N  = 4'(N_DIGITS);

  localparam logic [5:0] C_DASH = 6'b111111;
  localparam logic [5:0] C_U    = 6'b011111;
  localparam logic [5:0] C_S    = 6'b011011;
  localparam logic [5:0] C_P    = 6'b010101;
  localparam logic [5:0] C_E    = 6'b011101;
  localparam logic [5:0] C_B    = 6'b010111;
  localparam logic [5:0] C_C    = 6'b011001;
  localparam logic [5:0] C_G    = 6'b001101;

  typedef enum logic [2:0] {S_SET1, S_SET2, S_TURN, S_RESULT, S_WIN, S_DRAW} state_t;

  state_t          r_state, w_state_next;
  logic [SW_W-1:0] r_secret1, r_secret2, w_secret1_next, w_secret2_next;
  logic [3:0]      r_tries1, r_tries2, w_tries1_next, w_tries2_next;
  logic            r_turn, w_turn_next;          // 0 = player 1, 1 = player 2
  logic [3:0]      r_bulls, r_cows, w_bulls_res_next, w_cows_res_next;
  logic            r_p1_win, r_p2_win, r_draw;
  logic            w_p1_win_next, w_p2_win_next, w_draw_next;
  logic            r_ssl_prev, r_enter;
  logic [5:0]      r_disp [8];
  logic [5:0]      w_disp_next [8];

  logic [SW_W-1:0]     w_target;
  logic [N_DIGITS-1:0] w_in_range, w_bull_hit;
  logic                w_distinct, w_valid;
  logic [3:0]          w_bulls, w_cows;

  function automatic logic [5:0] dig(input logic [3:0] n);
    return {1'b0, n, 1'b0};
  endfunction

  // The active player always guesses the opponent's secret.
  assign w_target = r_turn ? r_secret1 : r_secret2;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [DIGIT_W-1:0] w_guess_digit, w_secret_digit;
      assign w_guess_digit  = bus.SW[gi*DIGIT_W +: DIGIT_W];
      assign w_secret_digit = w_target[gi*DIGIT_W +: DIGIT_W];
      assign w_in_range[gi] = (w_guess_digit <= MAX_D);
      assign w_bull_hit[gi] = (w_guess_digit == w_secret_digit);
    end
  endgenerate

  // Duplicate-digit check and bulls/cows tally of SW against the target code.
  always_comb begin
    w_distinct = 1'b1;
    w_bulls    = '0;
    w_cows     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_bull_hit[i]) w_bulls = w_bulls + 4'd1;
      for (int j = 0; j < N_DIGITS; j++) begin
        if (i != j) begin
          if (bus.SW[i*DIGIT_W +: DIGIT_W] == bus.SW[j*DIGIT_W +: DIGIT_W])
            w_distinct = 1'b0;
          if (w_target[i*DIGIT_W +: DIGIT_W] == bus.SW[j*DIGIT_W +: DIGIT_W])
            w_cows = w_cows + 4'd1;
        end
      end
    end
  end

  assign w_valid = w_distinct & (&w_in_range);

  // Registered rising-edge detect of the enter button; a level held through reset never counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ssl_prev <= 1'b1;
      r_enter    <= 1'b0;
    end else begin
      r_ssl_prev <= bus.ssl;
      r_enter    <= bus.ssl & ~r_ssl_prev;
    end
  end

  // Game next-state logic; game_over freezes everything.
  always_comb begin
    w_state_next     = r_state;
    w_secret1_next   = r_secret1;
    w_secret2_next   = r_secret2;
    w_tries1_next    = r_tries1;
    w_tries2_next    = r_tries2;
    w_turn_next      = r_turn;
    w_bulls_res_next = r_bulls;
    w_cows_res_next  = r_cows;
    w_p1_win_next    = r_p1_win;
    w_p2_win_next    = r_p2_win;
    w_draw_next      = r_draw;
    if (!bus.game_over && r_enter) begin
      case (r_state)
        S_SET1: if (w_valid) begin
          w_secret1_next = bus.SW;
          w_state_next   = S_SET2;
        end
        S_SET2: if (w_valid) begin
          w_secret2_next = bus.SW;
          w_tries1_next  = '0;
          w_tries2_next  = '0;
          w_turn_next    = 1'b0;
          w_state_next   = S_TURN;
        end
        S_TURN: if (w_valid) begin
          if (r_turn) w_tries2_next = r_tries2 + 4'd1;
          else        w_tries1_next = r_tries1 + 4'd1;
          w_bulls_res_next = w_bulls;
          w_cows_res_next  = w_cows;
          if (w_bulls == DIGITS_N) begin
            w_state_next = S_WIN;
            if (r_turn) w_p2_win_next = 1'b1;
            else        w_p1_win_next = 1'b1;
          end else begin
            w_state_next = S_RESULT;
          end
        end
        S_RESULT: begin
          if (r_tries1 == TRIES_MAX && r_tries2 == TRIES_MAX) begin
            w_state_next = S_DRAW;
            w_draw_next  = 1'b1;
          end else begin
            w_state_next = S_TURN;
            // Hand over only if the other player still has guesses left.
            if (r_turn) begin
              if (r_tries1 != TRIES_MAX) w_turn_next = 1'b0;
            end else begin
              if (r_tries2 != TRIES_MAX) w_turn_next = 1'b1;
            end
          end
        end
        default: w_state_next = S_SET1;   // WIN, DRAW acknowledge
      endcase
    end
  end

  // Display content for the state being entered, so it updates with the state.
  always_comb begin
    for (int k = 0; k < 8; k++) w_disp_next[k] = C_DASH;
    if (bus.game_over) begin
      w_disp_next[3] = C_G;
      w_disp_next[4] = C_G;
    end else begin
      case (w_state_next)
        S_SET1, S_SET2: begin
          w_disp_next[0] = C_U;
          w_disp_next[1] = C_S;
          w_disp_next[3] = dig((w_state_next == S_SET1) ? 4'd1 : 4'd2);
          w_disp_next[4] = C_P;
        end
        S_TURN: begin
          w_disp_next[0] = dig(w_turn_next ? 4'd2 : 4'd1);
          w_disp_next[1] = C_P;
          w_disp_next[3] = dig(TRIES_MAX - (w_turn_next ? w_tries2_next : w_tries1_next));
        end
        S_RESULT: begin
          w_disp_next[0] = C_C;
          w_disp_next[1] = dig(w_cows_res_next);
          w_disp_next[3] = C_B;
          w_disp_next[4] = dig(w_bulls_res_next);
        end
        S_WIN: begin
          w_disp_next[0] = C_E;
          w_disp_next[2] = C_B;
        end
        default: begin
          w_disp_next[0] = C_E;
          w_disp_next[2] = C_E;
        end
      endcase
    end
  end

  // State, game data, sticky outcome flags and display registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_SET1;
      r_secret1 <= '0;
      r_secret2 <= '0;
      r_tries1  <= '0;
      r_tries2  <= '0;
      r_turn    <= 1'b0;
      r_bulls   <= '0;
      r_cows    <= '0;
      r_p1_win  <= 1'b0;
      r_p2_win  <= 1'b0;
      r_draw    <= 1'b0;
      for (int k = 0; k < 8; k++) r_disp[k] <= C_DASH;
    end else begin
      r_state   <= w_state_next;
      r_secret1 <= w_secret1_next;
      r_secret2 <= w_secret2_next;
      r_tries1  <= w_tries1_next;
      r_tries2  <= w_tries2_next;
      r_turn    <= w_turn_next;
      r_bulls   <= w_bulls_res_next;
      r_cows    <= w_cows_res_next;
      r_p1_win  <= w_p1_win_next;
      r_p2_win  <= w_p2_win_next;
      r_draw    <= w_draw_next;
      for (int k = 0; k < 8; k++) r_disp[k] <= w_disp_next[k];
    end
  end

  assign bus.d1     = r_disp[0];
  assign bus.d2     = r_disp[1];
  assign bus.d3     = r_disp[2];
  assign bus.d4     = r_disp[3];
  assign bus.d5     = r_disp[4];
  assign bus.d6     = r_disp[5];
  assign bus.d7     = r_disp[6];
  assign bus.d8     = r_disp[7];
  assign bus.p1_win = r_p1_win;
  assign bus.p2_win = r_p2_win;
  assign bus.draw   = r_draw;
endmodule

// File: tb/tb_bulls_cows_param.sv
// Bench for bulls_cows_param: directed game scenarios plus random games,
// checked against a game-rules model through an expectation queue.
module tb_bulls_cows_param;
  localparam int N_DIGITS  = 4;
  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;
  localparam int MAX_TRIES = 8;
  localparam int SW_W      = N_DIGITS * DIGIT_W;

  logic clock = 1'b0;
  logic reset = 1'b0;

  bulls_cows_param_if #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) bus ();

  bulls_cows_param #(
    .N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W), .MAX_DIGIT(MAX_DIGIT), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // Game-rules model
  typedef enum {M_SET1, M_SET2, M_TURN, M_RESULT, M_WIN, M_DRAW} mstate_t;
  mstate_t m_state;
  int m_sec [2][N_DIGITS];
  int m_tries [2];
  int m_turn, m_bulls, m_cows;
  bit m_p1, m_p2, m_draw, m_go;

  int checks = 0;
  int errors = 0;

  int    q_due  [$];
  string q_disp [$];
  string q_name [$];
  logic [2:0] q_flags [$];

  function automatic int dig_of(input logic [SW_W-1:0] sw, input int i);
    return int'(sw[i*DIGIT_W +: DIGIT_W]);
  endfunction

  function automatic bit model_valid(input logic [SW_W-1:0] sw);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (dig_of(sw, i) > MAX_DIGIT) return 1'b0;
      for (int j = 0; j < i; j++)
        if (dig_of(sw, i) == dig_of(sw, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_SET1;
    m_tries[0] = 0; m_tries[1] = 0;
    m_turn = 0; m_bulls = 0; m_cows = 0;
    m_p1 = 0; m_p2 = 0; m_draw = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N_DIGITS; i++) m_sec[p][i] = 0;
  endtask

  task automatic model_enter(input logic [SW_W-1:0] sw);
    bit ok;
    int opp;
    ok = model_valid(sw);
    if (m_go) return;
    case (m_state)
      M_SET1: if (ok) begin
        for (int i = 0; i < N_DIGITS; i++) m_sec[0][i] = dig_of(sw, i);
        m_state = M_SET2;
      end
      M_SET2: if (ok) begin
        for (int i = 0; i < N_DIGITS; i++) m_sec[1][i] = dig_of(sw, i);
        m_tries[0] = 0; m_tries[1] = 0; m_turn = 0;
        m_state = M_TURN;
      end
      M_TURN: if (ok) begin
        opp = 1 - m_turn;
        m_bulls = 0; m_cows = 0;
        for (int i = 0; i < N_DIGITS; i++)
          for (int j = 0; j < N_DIGITS; j++)
            if (m_sec[opp][i] == dig_of(sw, j)) begin
              if (i == j) m_bulls++;
              else        m_cows++;
            end
        m_tries[m_turn]++;
        if (m_bulls == N_DIGITS) begin
          m_state = M_WIN;
          if (m_turn == 0) m_p1 = 1; else m_p2 = 1;
        end else begin
          m_state = M_RESULT;
        end
      end
      M_RESULT: begin
        if (m_tries[0] == MAX_TRIES && m_tries[1] == MAX_TRIES) begin
          m_state = M_DRAW; m_draw = 1;
        end else begin
          if (m_tries[1 - m_turn] < MAX_TRIES) m_turn = 1 - m_turn;
          m_state = M_TURN;
        end
      end
      default: m_state = M_SET1;
    endcase
  endtask

  function automatic string model_disp();
    if (m_go) return "---GG---";
    case (m_state)
      M_SET1:   return "US-1P---";
      M_SET2:   return "US-2P---";
      M_TURN:   return $sformatf("%0dP-%0d----", m_turn + 1, MAX_TRIES - m_tries[m_turn]);
      M_RESULT: return $sformatf("c%0d-b%0d---", m_cows, m_bulls);
      M_WIN:    return "E-b-----";
      default:  return "E-E-----";
    endcase
  endfunction

  function automatic logic [5:0] char2code(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) return {1'b0, 4'(ch - 8'h30), 1'b0};
    case (ch)
      "U":     return 6'b011111;
      "S":     return 6'b011011;
      "P":     return 6'b010101;
      "E":     return 6'b011101;
      "b":     return 6'b010111;
      "c":     return 6'b011001;
      "G":     return 6'b001101;
      default: return 6'b111111;
    endcase
  endfunction

  task automatic expect_at(input int due, input string name);
    q_due.push_back(due);
    q_disp.push_back(model_disp());
    q_name.push_back(name);
    q_flags.push_back({m_p1, m_p2, m_draw});
  endtask

  task automatic check_outputs(input string disp, input logic [2:0] fl, input string name);
    logic [47:0] act, req;
    logic [2:0]  act_fl;
    act    = {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7, bus.d8};
    act_fl = {bus.p1_win, bus.p2_win, bus.draw};
    for (int k = 0; k < 8; k++) req[47-6*k -: 6] = char2code(disp[k]);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s display actual=%h required=%h (%s)", name, act, req, disp);
    end
    checks++;
    if (act_fl !== fl) begin
      errors++;
      $display("FAIL %s flags p1/p2/draw actual=%b required=%b", name, act_fl, fl);
    end
    $display("txn %-18s expect=%s flags=%b", name, disp, fl);
  endtask

  // Monitor: compare whenever an expected response falls due.
  always @(negedge clock) begin
    if (q_due.size() > 0 && q_due[0] <= cycle) begin
      check_outputs(q_disp[0], q_flags[0], q_name[0]);
      void'(q_due.pop_front());
      void'(q_disp.pop_front());
      void'(q_name.pop_front());
      void'(q_flags.pop_front());
    end
  end

  task automatic press(input logic [SW_W-1:0] sw, input string name);
    @(negedge clock);
    bus.SW  = sw;
    bus.ssl = 1'b1;
    model_enter(sw);
    expect_at(cycle + 2, name);
    @(negedge clock);
    bus.ssl = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic set_go(input bit v, input string name);
    @(negedge clock);
    bus.game_over = v;
    m_go = v;
    expect_at(cycle + 1, name);
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset(input bit hold_ssl, input string name);
    logic [47:0] act;
    @(negedge clock);
    reset = 1'b1;
    if (hold_ssl) begin
      bus.ssl = 1'b1;
      bus.SW  = 16'h1234;
    end
    model_reset();
    #1;
    act = {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7, bus.d8};
    checks++;
    if (act !== {8{6'b111111}}) begin
      errors++;
      $display("FAIL %s in_reset_display actual=%h required=%h", name, act, {8{6'b111111}});
    end
    checks++;
    if ({bus.p1_win, bus.p2_win, bus.draw} !== 3'b000) begin
      errors++;
      $display("FAIL %s in_reset_flags actual=%b required=000", name,
               {bus.p1_win, bus.p2_win, bus.draw});
    end
    $display("txn %-18s expect=-------- (in reset)", name);
    @(negedge clock);
    reset = 1'b0;
    expect_at(cycle + 4, name);
    repeat (6) @(negedge clock);
    bus.ssl = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [SW_W-1:0] rand_sw();
    int r;
    int pool [10];
    int j, t;
    logic [SW_W-1:0] v;
    r = $urandom_range(0, 99);
    v = '0;
    if (r < 15) return SW_W'($urandom);
    if (r < 23 && m_state == M_TURN) begin
      for (int i = 0; i < N_DIGITS; i++) v[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(m_sec[1 - m_turn][i]);
      return v;
    end
    for (int i = 0; i < 10; i++) pool[i] = i;
    for (int i = 9; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = pool[i]; pool[i] = pool[j]; pool[j] = t;
    end
    for (int i = 0; i < N_DIGITS; i++) v[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(pool[i]);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bus.SW = '0;
    bus.ssl = 1'b0;
    bus.game_over = 1'b0;
    m_go = 1'b0;
    model_reset();
    do_reset(1'b0, "reset");

    // P1 wins on the first guess
    press(16'h1234, "t1_secret1");
    press(16'h5678, "t1_secret2");
    press(16'h5678, "t1_p1_win");
    press(16'h0000, "t1_ack");

    // Invalid codes are ignored in SET1
    press(16'h1123, "t2_dup_digit");
    press(16'h12A4, "t2_out_of_range");
    press(16'h1234, "t2_accept");

    // Four cows, no bulls
    press(16'h1234, "t3_secret2");
    press(16'h4321, "t3_c4_b0");
    press(16'h0000, "t3_to_p2");

    // Abort freezes; enter while frozen is ignored
    set_go(1'b1, "t5_go_on");
    press(16'h5678, "t5_enter_frozen");
    set_go(1'b0, "t5_go_off");

    // Reset in RESULT with ssl held across it
    press(16'h5670, "t6_p2_guess");
    do_reset(1'b1, "reset_mid_result");

    // Win on the final allowed guess
    press(16'h1234, "fw_secret1");
    press(16'h5678, "fw_secret2");
    for (int k = 0; k < 2*MAX_TRIES - 1; k++) begin
      press(16'h9876, $sformatf("fw_miss%0d", k));
      press(16'h0000, $sformatf("fw_ack%0d", k));
    end
    press(16'h1234, "fw_p2_final_win");
    press(16'h0000, "fw_ack_win");

    // Both players exhausted -> draw
    press(16'h1234, "dr_secret1");
    press(16'h5678, "dr_secret2");
    for (int k = 0; k < 2*MAX_TRIES; k++) begin
      press(16'h9876, $sformatf("dr_miss%0d", k));
      press(16'h0000, $sformatf("dr_ack%0d", k));
    end
    press(16'h0000, "dr_ack_draw");

    // Random games
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (m_state != M_WIN && m_state != M_DRAW && n < 200) begin
        press(rand_sw(), $sformatf("rnd%0d_%0d", g, n));
        n++;
      end
      press(rand_sw(), $sformatf("rnd%0d_end", g));
    end

    repeat (5) @(negedge clock);
    checks++;
    if (q_due.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q_due.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
